// File: rtl/palette_pkg.sv
// Shared types and constants for the writable, multi-bank colour palette.
package palette_pkg;

  localparam int unsigned CH_W_DEFAULT = 4;

  typedef struct packed {
    logic [CH_W_DEFAULT-1:0] r;
    logic [CH_W_DEFAULT-1:0] g;
    logic [CH_W_DEFAULT-1:0] b;
  } rgb_t;

  typedef enum logic [0:0] {
    StClear,
    StIdle
  } state_e;

  localparam rgb_t BLACK = '{r: '0, g: '0, b: '0};

endpackage

// File: rtl/palette_bank_ram.sv
// Simple dual-port palette storage: one write port, one registered read port, read-first.
module palette_bank_ram #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 12,
  parameter int unsigned Depth = 1024
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem [Depth];

  // Read and write share one process so a same-address collision returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/palette_ram_lut.sv
// Colour index to packed RGB lookup with runtime writes, frame-synchronous bank switching,
// transparency flag, blanking and a clear sweep after reset or on request.
module palette_ram_lut
  import palette_pkg::*;
#(
  parameter int unsigned INDEX_W        = 8,
  parameter int unsigned CH_W           = CH_W_DEFAULT,
  parameter int unsigned NUM_BANKS      = 4,
  parameter bit          TRANSP_EN      = 1'b1,
  parameter int unsigned TRANSP_INDEX   = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  localparam int unsigned BANK_W        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_start,
  input  logic [BANK_W-1:0]   bank_sel,
  input  logic                rd_valid,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic                rd_blank,
  output logic                out_valid,
  output logic [CH_W-1:0]     red,
  output logic [CH_W-1:0]     green,
  output logic [CH_W-1:0]     blue,
  output logic                out_transp,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [BANK_W-1:0]   wr_bank,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [3*CH_W-1:0]   wr_data,
  input  logic                clear_req,
  output logic                busy
);

  localparam int unsigned ADDR_W = BANK_W + INDEX_W;
  localparam int unsigned DATA_W = 3 * CH_W;
  localparam int unsigned DEPTH  = NUM_BANKS << INDEX_W;
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [BANK_W:0]    BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [INDEX_W-1:0] TRANSP_KEY = INDEX_W'(TRANSP_INDEX);
  localparam state_e             RESET_STATE = CLEAR_ON_RESET ? StClear : StIdle;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [BANK_W-1:0]   pending_bank_q, active_bank_q;
  logic                s1_valid_q, s1_blank_q, s1_transp_q, s1_busy_q;
  logic [DATA_W-1:0]   out_rgb_q;

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ram_we    = 1'b0;
    ram_waddr = {wr_bank, wr_index};
    ram_wdata = wr_data;
    unique case (state_q)
      StClear: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StIdle: begin
        // Writes to a non-existent bank are accepted but dropped.
        ram_we = wr_valid && ({1'b0, wr_bank} < BANK_LIMIT);
        if (clear_req) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      default: state_d = RESET_STATE;
    endcase
  end

  assign busy     = (state_q == StClear);
  assign wr_ready = (state_q == StIdle);

  palette_bank_ram #(
    .AddrW (ADDR_W),
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i ({active_bank_q, rd_index}),
    .rdata_o (ram_rdata)
  );

  // Stage 1 shadows the RAM read register; stage 2 holds the visible outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pending_bank_q <= '0;
      active_bank_q  <= '0;
      s1_valid_q     <= 1'b0;
      s1_blank_q     <= 1'b0;
      s1_transp_q    <= 1'b0;
      s1_busy_q      <= 1'b0;
      out_valid      <= 1'b0;
      out_transp     <= 1'b0;
      out_rgb_q      <= '0;
    end else begin
      pending_bank_q <= bank_sel;
      if (frame_start) begin
        active_bank_q <= pending_bank_q;
      end
      s1_valid_q  <= rd_valid;
      s1_blank_q  <= rd_blank;
      s1_busy_q   <= busy;
      s1_transp_q <= TRANSP_EN && (rd_index == TRANSP_KEY);
      out_valid   <= s1_valid_q;
      if (s1_valid_q) begin
        out_transp <= s1_transp_q;
        out_rgb_q  <= (s1_blank_q || s1_busy_q) ? '0 : ram_rdata;
      end
    end
  end

  assign {red, green, blue} = out_rgb_q;

endmodule

// File: tb/tb_palette_ram_lut.sv
// Directed and randomized checks of palette_ram_lut against a flat-array reference model.
module tb_palette_ram_lut;

  logic       Clk = 1'b0;
  logic       Reset_n, frame_start, rd_valid, rd_blank, wr_valid, clear_req;
  logic [1:0] bank_sel, wr_bank;
  logic [7:0] rd_index, wr_index;
  logic [11:0] wr_data;
  logic       out_valid, out_transp, wr_ready, busy;
  logic [3:0] red, green, blue;

  always #5 Clk = ~Clk;

  palette_ram_lut dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .bank_sel    (bank_sel),
    .rd_valid    (rd_valid),
    .rd_index    (rd_index),
    .rd_blank    (rd_blank),
    .out_valid   (out_valid),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .out_transp  (out_transp),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_bank     (wr_bank),
    .wr_index    (wr_index),
    .wr_data     (wr_data),
    .clear_req   (clear_req),
    .busy        (busy)
  );

  int unsigned nvec  = 0;
  int unsigned nfail = 0;

  // Reference model: 4 banks x 256 entries, flat array indexed bank*256+index.
  typedef struct packed {
    logic        v;
    logic [11:0] rgb;
    logic        t;
  } res_t;

  logic [11:0] mem_m [1024];
  int          act_m, pend_m, clr_m;
  bit          busy_m;
  res_t        pipe_q[$];
  logic [11:0] exp_rgb;
  logic        exp_t;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    nvec++;
    assert (got === want) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    act_m   = 0;
    pend_m  = 0;
    clr_m   = 0;
    busy_m  = 1'b1;
    exp_rgb = '0;
    exp_t   = 1'b0;
    pipe_q.delete();
    pipe_q.push_back('0);
  endtask

  // One clock: model the cycle, advance the DUT, compare every output, drop pulses.
  task automatic cycle();
    res_t r, o;
    r = '0;
    if (rd_valid) begin
      r.v   = 1'b1;
      r.t   = (rd_index == 8'h00);
      r.rgb = (busy_m || rd_blank) ? 12'h000 : mem_m[act_m * 256 + int'(rd_index)];
    end
    pipe_q.push_back(r);
    if (busy_m) begin
      mem_m[clr_m] = 12'h000;
      clr_m++;
      if (clr_m == 1024) busy_m = 1'b0;
    end else begin
      if (wr_valid) mem_m[int'(wr_bank) * 256 + int'(wr_index)] = wr_data;
      if (clear_req) begin
        busy_m = 1'b1;
        clr_m  = 0;
      end
    end
    if (frame_start) act_m = pend_m;
    pend_m = int'(bank_sel);
    @(posedge Clk);
    #1;
    o = pipe_q.pop_front();
    if (o.v) begin
      exp_rgb = o.rgb;
      exp_t   = o.t;
    end
    chk("out_valid", {15'b0, out_valid}, {15'b0, o.v});
    chk("colour", {4'b0, red, green, blue}, {4'b0, exp_rgb});
    chk("out_transp", {15'b0, out_transp}, {15'b0, exp_t});
    chk("busy", {15'b0, busy}, {15'b0, busy_m});
    chk("wr_ready", {15'b0, wr_ready}, {15'b0, !busy_m});
    frame_start = 1'b0;
    rd_valid    = 1'b0;
    rd_blank    = 1'b0;
    wr_valid    = 1'b0;
    clear_req   = 1'b0;
  endtask

  task automatic lookup(input logic [7:0] idx, input logic blank);
    rd_valid = 1'b1;
    rd_index = idx;
    rd_blank = blank;
    cycle();
    cycle();
  endtask

  task automatic wr(input logic [1:0] bank, input logic [7:0] idx, input logic [11:0] data);
    wr_valid = 1'b1;
    wr_bank  = bank;
    wr_index = idx;
    wr_data  = data;
    cycle();
  endtask

  task automatic count_sweep(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      cycle();
      n++;
    end
    chk(tag, 16'(n), 16'd1024);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, {15'b0, out_valid}, 16'h0000);
    chk({tag, "_rgb"}, {4'b0, red, green, blue}, 16'h0000);
    chk({tag, "_transp"}, {15'b0, out_transp}, 16'h0000);
    chk({tag, "_wr_ready"}, {15'b0, wr_ready}, 16'h0000);
    chk({tag, "_busy"}, {15'b0, busy}, 16'h0001);
  endtask

  initial begin
    Reset_n = 1'b0;
    frame_start = 1'b0; rd_valid = 1'b0; rd_blank = 1'b0; wr_valid = 1'b0; clear_req = 1'b0;
    bank_sel = '0; wr_bank = '0; rd_index = '0; wr_index = '0; wr_data = '0;
    #12;
    check_reset_outputs("reset");
    model_reset();
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    count_sweep("clear_len");
    lookup(8'h55, 1'b0);
    chk("idx55_black", {4'b0, red, green, blue}, 16'h0000);

    wr(2'd0, 8'h03, 12'h683);
    wr(2'd0, 8'h01, 12'h5A5);
    frame_start = 1'b1;
    cycle();
    lookup(8'h03, 1'b0);
    chk("b0_valid", {15'b0, out_valid}, 16'h0001);
    chk("b0_idx3", {4'b0, red, green, blue}, 16'h0683);

    wr(2'd1, 8'h03, 12'hF00);
    bank_sel = 2'd1;
    cycle();
    cycle();
    lookup(8'h03, 1'b0);
    chk("sel_no_frame", {4'b0, red, green, blue}, 16'h0683);
    frame_start = 1'b1;
    cycle();
    lookup(8'h03, 1'b0);
    chk("b1_idx3", {4'b0, red, green, blue}, 16'h0F00);

    bank_sel = 2'd0;
    cycle();
    cycle();
    frame_start = 1'b1;
    lookup(8'h03, 1'b0);
    chk("frame_same_cycle", {4'b0, red, green, blue}, 16'h0F00);
    lookup(8'h03, 1'b0);
    chk("after_switch", {4'b0, red, green, blue}, 16'h0683);

    wr_valid = 1'b1; wr_bank = 2'd0; wr_index = 8'h10; wr_data = 12'hABC;
    rd_valid = 1'b1; rd_index = 8'h10;
    cycle();
    rd_valid = 1'b1; rd_index = 8'h10;
    cycle();
    chk("collide_old", {4'b0, red, green, blue}, 16'h0000);
    cycle();
    chk("collide_new", {4'b0, red, green, blue}, 16'h0ABC);

    lookup(8'h00, 1'b0);
    chk("transp_idx0", {15'b0, out_transp}, 16'h0001);
    lookup(8'h01, 1'b0);
    chk("idx1_plain", {4'b0, red, green, blue}, 16'h05A5);
    lookup(8'h01, 1'b1);
    chk("blank_rgb", {4'b0, red, green, blue}, 16'h0000);
    chk("blank_transp", {15'b0, out_transp}, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      frame_start = ($urandom_range(0, 7) == 0);
      bank_sel    = 2'($urandom_range(0, 3));
      rd_valid    = ($urandom_range(0, 3) != 0);
      rd_index    = 8'($urandom_range(0, 15));
      rd_blank    = ($urandom_range(0, 7) == 0);
      wr_valid    = ($urandom_range(0, 1) == 1);
      wr_bank     = 2'($urandom_range(0, 3));
      wr_index    = 8'($urandom_range(0, 15));
      wr_data     = 12'($urandom);
      cycle();
    end

    // Soft clear: writes ignored, reads black, then reset mid-sweep restarts it.
    clear_req = 1'b1;
    cycle();
    chk("clear_wr_ready", {15'b0, wr_ready}, 16'h0000);
    lookup(8'h01, 1'b0);
    chk("clear_black", {4'b0, red, green, blue}, 16'h0000);
    for (int i = 0; i < 60; i++) begin
      wr_valid = 1'b1;
      wr_bank  = 2'($urandom_range(0, 3));
      wr_index = 8'($urandom_range(0, 15));
      wr_data  = 12'($urandom);
      rd_valid = 1'b1;
      rd_index = (i >= 58) ? 8'h00 : 8'($urandom_range(0, 15));
      cycle();
    end
    Reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    model_reset();
    bank_sel = 2'd0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    count_sweep("restart_len");
    lookup(8'h03, 1'b0);
    chk("cleared_idx3", {4'b0, red, green, blue}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/palette_ram_lut.md
Name: palette_ram_lut

Overview:
- Writable, multi-bank successor to the fixed 256-entry ROM palette. Maps a pixel colour index to packed 4:4:4 RGB.
- Sits between the sprite/background pixel fetch and the VGA colour output.
- Adds a runtime write port, NUM_BANKS selectable palettes with frame-synchronous bank switching, a transparency key flag, blanking, and a reset-time clear sequencer.

Parameters:
- INDEX_W, 8, colour index width; each bank holds 2^INDEX_W entries.
- CH_W, 4, bits per colour channel; entry width is 3*CH_W.
- NUM_BANKS, 4, number of palettes; BANK_W = max(1, clog2(NUM_BANKS)).
- TRANSP_EN, 1, enables the transparency flag.
- TRANSP_INDEX, 0, index value reported as transparent.
- CLEAR_ON_RESET, 1, when set, a clear sweep runs after reset.

Ports:
- Clk  in  1  system clock.
- Reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse at frame boundary (vsync).
- bank_sel  in  BANK_W  requested display bank; applied at frame_start.
- rd_valid  in  1  lookup request qualifier.
- rd_index  in  INDEX_W  colour index to look up.
- rd_blank  in  1  forces the output colour to black.
- out_valid  out  1  rd_valid delayed by 2 cycles.
- red, green, blue  out  CH_W each  looked-up colour.
- out_transp  out  1  index matched TRANSP_INDEX (0 if TRANSP_EN=0).
- wr_valid  in  1  palette write request.
- wr_ready  out  1  write can be accepted.
- wr_bank  in  BANK_W  target bank.
- wr_index  in  INDEX_W  target entry.
- wr_data  in  3*CH_W  {R,G,B}.
- clear_req  in  1  pulse: start a soft clear of all banks.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset (async, Reset_n=0):
  - out_valid, red, green, blue, out_transp = 0.
  - active_bank = 0, pending_bank = 0.
  - wr_ready = 0.
  - State = CLEAR if CLEAR_ON_RESET, else IDLE. busy mirrors (state==CLEAR).
  - RAM contents are not reset.
- FSM:
  - IDLE: wr_ready=1; clear_req -> CLEAR.
  - CLEAR: writes 0 to address clr_cnt, one entry per cycle. clr_cnt is a flat counter over NUM_BANKS*2^INDEX_W entries, starting at 0. After the last entry -> IDLE. Total duration is NUM_BANKS*2^INDEX_W cycles; wr_ready=0 throughout. clear_req during CLEAR is ignored.
  - Reset asserted mid-sweep restarts the sweep from 0.
- Write:
  - Accepted when wr_valid && wr_ready. Stored at the next Clk edge to {wr_bank, wr_index}.
  - wr_bank >= NUM_BANKS: write is accepted and discarded.
- Bank switch:
  - bank_sel is sampled into pending_bank every cycle.
  - active_bank <= pending_bank only on frame_start. A bank_sel change mid-frame has no effect until the next frame_start.
  - frame_start together with an rd_valid: that lookup uses the old active_bank.
- Lookup pipeline, fixed latency 2:
  - Stage 1 registers the RAM read of {active_bank, rd_index}, plus valid, blank, and transp = TRANSP_EN && (rd_index==TRANSP_INDEX).
  - Stage 2 drives the outputs: colour = 0 if blank or busy-at-stage-1, else RAM data.
  - out_valid always follows rd_valid with a delay of 2 cycles. When out_valid=0 the outputs hold their previous values.
- Read/write collision: a read and a write to the same address in the same cycle returns the OLD data (read-first). The next-cycle read returns the new data.
- Read throughput is 1 per cycle, with no backpressure on the read side. Writes never stall reads.

Decomposition:
- palette_pkg: CH_W default, rgb_t packed struct {r,g,b}, state enum {CLEAR, IDLE}, BLACK constant.
- One sub-module, palette_bank_ram: simple dual-port inferred RAM (one write, one registered read, read-first), depth NUM_BANKS*2^INDEX_W.
- palette_ram_lut holds the FSM, bank registers and output stage.

Test Plan:
- Reset then wait: busy=1 for exactly 1024 cycles (defaults), then wr_ready=1. A lookup of bank 0 index 0x55 returns 0,0,0.
- Write bank0 idx 0x03 = 0x683, frame_start with bank_sel=0, read idx 0x03 -> two cycles later out_valid=1, R=6 G=8 B=3.
- Write bank1 idx 0x03 = 0xF00; set bank_sel=1 without frame_start -> read still returns 0x683. Pulse frame_start, read again -> 0xF00.
- Write and read idx 0x10 in the same cycle (old value 0x000, new 0xABC) -> first result 0x000, next-cycle read 0xABC.
- Read idx 0x00 -> out_transp=1. Read idx 0x01 with rd_blank=1 -> colour 0x000, out_transp=0.
- Pulse clear_req after filling entries -> wr_ready drops, wr_valid is ignored, lookups return black until busy clears. Assert Reset_n low mid-sweep -> outputs zero at once, and the sweep restarts from 0.
